guess_filter: RTL and testbench
===============================

GUESS_FILTER -- requirements
Module: guess_filter

Interface
REQ-001 Parameter LIVES, default 4: wrong guesses allowed per round (1..15).
REQ-002 Parameter TIMEOUT, default 15: cycles to wait for a verdict before abandoning a guess (1..255).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 key_make  input  1  level from the keyboard driver; high while a key is in the make state.
REQ-006 key_letter  input  5  decoded key: 0-25 = A-Z, 26 = start, 27-31 = ignore.
REQ-007 game_over  input  1  level from level select; high when the round is won.
REQ-008 guess_valid  output  1  one-cycle strobe presenting a new, never-before-guessed letter.
REQ-009 guess_letter  output  5  letter qualified by guess_valid; held stable until the next strobe.
REQ-010 verdict_valid  input  1  one-cycle strobe from game state carrying the result of the pending guess.
REQ-011 verdict_hit  input  1  qualified by verdict_valid: 1 = letter is in the word, 0 = miss.
REQ-012 start_game  output  1  one-cycle strobe on an accepted start key.
REQ-013 guessed  output  26  bit n set once letter n has been issued this round.
REQ-014 lives  output  4  remaining wrong guesses.
REQ-015 lost  output  1  high while lives == 0 in a started round.
REQ-016 busy  output  1  high while a guess awaits its verdict.
REQ-017 timeout_err  output  1  sticky; set when a verdict times out.

Function
REQ-018 A key event is the rising edge of key_make, detected by a registered previous value. The block samples key_letter in the same cycle. Held keys and auto-repeat produce no further events.
REQ-019 FSM states are IDLE, READY, WAIT, OVER; the reset state is IDLE.
REQ-020 IDLE: a start event (code 26) goes to READY and pulses start_game. In the same cycle it clears guessed, loads lives = LIVES, and clears timeout_err. All other events are ignored.
REQ-021 READY, letter event (0-25) with guessed[letter] = 0: on the next cycle, guess_valid = 1, guess_letter = letter, guessed[letter] is set, and the state goes to WAIT. Latency from the key_make edge to guess_valid is 1 cycle.
REQ-022 READY, letter event with guessed[letter] = 1: dropped; no strobe and no state change.
REQ-023 READY, codes 27-31: dropped.
REQ-024 READY, start event: restarts the round with identical actions to REQ-020; the state stays READY.
REQ-025 WAIT: all key events are dropped (no queueing).
REQ-026 WAIT, verdict with hit = 1: lives is unchanged; the state goes to READY.
REQ-027 WAIT, verdict with hit = 0: lives decrements by 1. If the result is 0, lost = 1 and the state goes to OVER; otherwise the state goes to READY.
REQ-028 WAIT timer: counts cycles since guess_valid. If TIMEOUT cycles pass with no verdict, set timeout_err and go to READY with lives unchanged; guessed keeps the letter.
REQ-029 A verdict_valid outside WAIT is ignored.
REQ-030 If a verdict and the timeout fall in the same cycle, the verdict wins.
REQ-031 game_over = 1 in READY or WAIT goes to OVER; a pending verdict is discarded.
REQ-032 OVER: only a start event is honoured; it behaves as REQ-020 and goes to READY.
REQ-033 lives never underflows below 0.
REQ-034 lost is a combinational decode of lives == 0 in state OVER.
REQ-035 busy = 1 exactly in WAIT.
REQ-036 Outputs are registered except lost and busy.

Reset
REQ-037 reset_n = 0 asynchronously forces the following, at any point mid-operation:
- state = IDLE
- guess_valid = 0, start_game = 0
- guess_letter = 0, guessed = 0
- lives = LIVES
- timeout_err = 0
- WAIT timer = 0
- previous key_make = 0
REQ-038 On reset release, the first rising key_make edge is treated as a new event.

Verification
REQ-039 Reset; start (26); letter 4 (E) → guess_valid one cycle after the make edge with guess_letter = 4, guessed = 0x0000010, busy = 1.
REQ-040 With E pending, a verdict miss → lives 4→3, state READY. Pressing E again → no guess_valid, lives stays 3.
REQ-041 LIVES = 4: four distinct letters, each with a miss verdict → lives = 0, lost = 1, state OVER. A fifth letter is ignored. Start → lives = 4, guessed = 0, lost = 0.
REQ-042 TIMEOUT = 15: guess, no verdict for 15 cycles → timeout_err = 1, state READY, lives unchanged. A verdict arriving at cycle 15 takes priority, with timeout_err = 0.
REQ-043 Hold key_make high for 1000 cycles → exactly one guess_valid. A second letter pressed during WAIT → dropped.
REQ-044 Assert reset_n = 0 during WAIT → outputs take the REQ-037 values immediately, without waiting for a clock edge. A verdict after release → ignored.

Source files
------------

// File: rtl/guess_filter.sv
// Letter-guess filter for a hangman-style game: turns key make edges into
// de-duplicated guess strobes and tracks lives, verdict wait and timeout.
module guess_filter #(
  parameter int unsigned LIVES   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_make,
  input  logic [4:0]  key_letter,
  input  logic        game_over,
  output logic        guess_valid,
  output logic [4:0]  guess_letter,
  input  logic        verdict_valid,
  input  logic        verdict_hit,
  output logic        start_game,
  output logic [25:0] guessed,
  output logic [3:0]  lives,
  output logic        lost,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, READY, WAIT, OVER} state_e;

  localparam logic [3:0] LIVES_INIT = 4'(LIVES);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic        key_prev_q;
  logic        guess_valid_q;
  logic [4:0]  guess_letter_q;
  logic        start_game_q;
  logic [25:0] guessed_q;
  logic [3:0]  lives_q;
  logic        timeout_err_q;
  logic [7:0]  timer_q;

  logic        key_rise;
  logic        is_start;
  logic        is_letter;
  logic [25:0] letter_mask;
  logic        already;
  logic        do_start;

  assign key_rise    = key_make & ~key_prev_q;
  assign is_start    = (key_letter == 5'd26);
  assign is_letter   = (key_letter < 5'd26);
  assign letter_mask = 26'd1 << key_letter;
  assign already     = |(guessed_q & letter_mask);

  // game_over in READY pre-empts any key event that cycle, including start
  assign do_start = key_rise && is_start &&
                    (state_q == IDLE || state_q == OVER ||
                     (state_q == READY && !game_over));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      key_prev_q     <= 1'b0;
      guess_valid_q  <= 1'b0;
      guess_letter_q <= '0;
      start_game_q   <= 1'b0;
      guessed_q      <= '0;
      lives_q        <= LIVES_INIT;
      timeout_err_q  <= 1'b0;
      timer_q        <= '0;
    end else begin
      key_prev_q    <= key_make;
      guess_valid_q <= 1'b0;
      start_game_q  <= 1'b0;
      if (do_start) begin
        state_q       <= READY;
        start_game_q  <= 1'b1;
        guessed_q     <= '0;
        lives_q       <= LIVES_INIT;
        timeout_err_q <= 1'b0;
      end else begin
        case (state_q)
          READY: begin
            if (game_over) begin
              state_q <= OVER;
            end else if (key_rise && is_letter && !already) begin
              guess_valid_q  <= 1'b1;
              guess_letter_q <= key_letter;
              guessed_q      <= guessed_q | letter_mask;
              timer_q        <= '0;
              state_q        <= WAIT;
            end
          end
          WAIT: begin
            // priority: game_over, then verdict, then timeout
            if (game_over) begin
              state_q <= OVER;
            end else if (verdict_valid) begin
              if (verdict_hit) begin
                state_q <= READY;
              end else if (lives_q <= 4'd1) begin
                lives_q <= '0;
                state_q <= OVER;
              end else begin
                lives_q <= lives_q - 4'd1;
                state_q <= READY;
              end
            end else if (timer_q == TIMER_LAST) begin
              timeout_err_q <= 1'b1;
              state_q       <= READY;
            end else begin
              timer_q <= timer_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign guess_valid  = guess_valid_q;
  assign guess_letter = guess_letter_q;
  assign start_game   = start_game_q;
  assign guessed      = guessed_q;
  assign lives        = lives_q;
  assign timeout_err  = timeout_err_q;
  assign lost         = (state_q == OVER) && (lives_q == 4'd0);
  assign busy         = (state_q == WAIT);

endmodule

// File: tb/tb_guess_filter.sv
// Self-checking bench for guess_filter: vector table plus hand-written
// sequences, with a queue scoreboard for issued guesses.
module tb_guess_filter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        key_make;
  logic [4:0]  key_letter;
  logic        game_over;
  logic        guess_valid;
  logic [4:0]  guess_letter;
  logic        verdict_valid;
  logic        verdict_hit;
  logic        start_game;
  logic [25:0] guessed;
  logic [3:0]  lives;
  logic        lost;
  logic        busy;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;
  int gv_count = 0;
  logic [4:0] exp_q[$];

  guess_filter #(.LIVES(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .key_make(key_make), .key_letter(key_letter),
    .game_over(game_over), .guess_valid(guess_valid), .guess_letter(guess_letter),
    .verdict_valid(verdict_valid), .verdict_hit(verdict_hit),
    .start_game(start_game), .guessed(guessed), .lives(lives), .lost(lost),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every guess strobe must match the oldest expected letter
  always @(negedge clk) begin
    if (guess_valid === 1'b1) begin
      gv_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_guess: got letter %0d expected none at %0t", guess_letter, $time);
      end else begin
        check("guess_letter", 32'(guess_letter), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic press(input logic [4:0] l, input bit expv);
    if (expv) exp_q.push_back(l);
    @(negedge clk);
    key_make   = 1'b1;
    key_letter = l;
    @(negedge clk);
    check("guess_valid", 32'(guess_valid), 32'(expv));
    key_make = 1'b0;
  endtask

  task automatic verdict(input logic h);
    verdict_valid = 1'b1;
    verdict_hit   = h;
    @(negedge clk);
    verdict_valid = 1'b0;
    verdict_hit   = 1'b0;
  endtask

  task automatic restart();
    press(5'd26, 1'b0);
    check("start_game", 32'(start_game), 32'd1);
    check("lives_restart", 32'(lives), 32'd4);
    check("guessed_restart", 32'(guessed), 32'd0);
    check("lost_restart", 32'(lost), 32'd0);
  endtask

  typedef struct {
    logic [4:0] letter;
    logic       hit;
    logic       exp_valid;
    logic [3:0] exp_lives;
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [25:0] mask;
    int gv_before;

    vecs[0] = '{letter: 5'd4,  hit: 1'b0, exp_valid: 1'b0, exp_lives: 4'd3};
    vecs[1] = '{letter: 5'd0,  hit: 1'b1, exp_valid: 1'b1, exp_lives: 4'd3};
    vecs[2] = '{letter: 5'd28, hit: 1'b0, exp_valid: 1'b0, exp_lives: 4'd3};
    vecs[3] = '{letter: 5'd25, hit: 1'b0, exp_valid: 1'b1, exp_lives: 4'd2};
    vecs[4] = '{letter: 5'd0,  hit: 1'b0, exp_valid: 1'b0, exp_lives: 4'd2};
    vecs[5] = '{letter: 5'd31, hit: 1'b0, exp_valid: 1'b0, exp_lives: 4'd2};
    vecs[6] = '{letter: 5'd7,  hit: 1'b1, exp_valid: 1'b1, exp_lives: 4'd2};

    reset_n = 1'b0; key_make = 1'b0; key_letter = '0; game_over = 1'b0;
    verdict_valid = 1'b0; verdict_hit = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_lives", 32'(lives), 32'd4);
    check("rst_guessed", 32'(guessed), 32'd0);
    check("rst_guess_valid", 32'(guess_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lost", 32'(lost), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset_n = 1'b1;

    // letter before start is ignored in IDLE
    press(5'd2, 1'b0);
    restart();
    @(negedge clk);
    check("start_pulse_width", 32'(start_game), 32'd0);

    // first guess: E
    press(5'd4, 1'b1);
    check("guessed_E", 32'(guessed), 32'h10);
    check("busy_E", 32'(busy), 32'd1);
    verdict(1'b0);
    check("lives_after_E", 32'(lives), 32'd3);
    check("busy_after_E", 32'(busy), 32'd0);

    mask = 26'h10;
    for (int unsigned i = 0; i < 7; i++) begin
      press(vecs[i].letter, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check("vec_busy", 32'(busy), 32'd1);
        mask = mask | (26'd1 << vecs[i].letter);
      end
      verdict(vecs[i].hit);
      check("vec_lives", 32'(lives), 32'(vecs[i].exp_lives));
      check("vec_idle_busy", 32'(busy), 32'd0);
    end
    check("vec_guessed", 32'(guessed), 32'(mask));

    // lose a round: four misses from full lives
    restart();
    for (int unsigned k = 0; k < 4; k++) begin
      press(5'(10 + k), 1'b1);
      verdict(1'b0);
      check("lose_lives", 32'(lives), 32'(3 - k));
    end
    check("lost_set", 32'(lost), 32'd1);
    check("lost_busy", 32'(busy), 32'd0);
    press(5'd14, 1'b0);
    verdict(1'b0);
    check("lives_floor", 32'(lives), 32'd0);
    restart();

    // timeout after 15 WAIT cycles, guessed keeps the letter
    press(5'd5, 1'b1);
    repeat (14) @(negedge clk);
    check("to_busy_before", 32'(busy), 32'd1);
    check("to_err_before", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("to_busy_after", 32'(busy), 32'd0);
    check("to_err_after", 32'(timeout_err), 32'd1);
    check("to_lives", 32'(lives), 32'd4);
    check("to_guessed", 32'(guessed), 32'h20);
    verdict(1'b0);
    check("late_verdict_lives", 32'(lives), 32'd4);

    // verdict on the final WAIT cycle beats the timeout
    restart();
    check("restart_clears_err", 32'(timeout_err), 32'd0);
    press(5'd6, 1'b1);
    repeat (14) @(negedge clk);
    verdict(1'b0);
    check("edge_verdict_err", 32'(timeout_err), 32'd0);
    check("edge_verdict_lives", 32'(lives), 32'd3);
    check("edge_verdict_busy", 32'(busy), 32'd0);

    // game_over during WAIT discards the pending verdict
    restart();
    press(5'd15, 1'b1);
    game_over = 1'b1;
    @(negedge clk);
    game_over = 1'b0;
    verdict(1'b0);
    check("go_lives", 32'(lives), 32'd4);
    check("go_busy", 32'(busy), 32'd0);
    check("go_lost", 32'(lost), 32'd0);
    press(5'd16, 1'b0);
    restart();

    // held key produces exactly one guess
    gv_before = gv_count;
    exp_q.push_back(5'd8);
    @(negedge clk);
    key_make = 1'b1; key_letter = 5'd8;
    repeat (1000) @(negedge clk);
    key_make = 1'b0;
    check("hold_one_guess", 32'(gv_count - gv_before), 32'd1);
    check("hold_timeout_err", 32'(timeout_err), 32'd1);

    // second key during WAIT is dropped, not queued
    press(5'd9, 1'b1);
    press(5'd17, 1'b0);
    verdict(1'b1);
    @(negedge clk);
    check("no_queued_guess", 32'(busy), 32'd0);
    press(5'd17, 1'b1);
    check("guessed_17", 32'(guessed[17]), 32'd1);

    // asynchronous reset while a guess is pending
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_guess_valid", 32'(guess_valid), 32'd0);
    check("arst_guess_letter", 32'(guess_letter), 32'd0);
    check("arst_guessed", 32'(guessed), 32'd0);
    check("arst_lives", 32'(lives), 32'd4);
    check("arst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    verdict(1'b0);
    check("post_rst_verdict", 32'(lives), 32'd4);
    press(5'd3, 1'b0);
    press(5'd26, 1'b0);
    check("post_rst_start", 32'(start_game), 32'd1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
